// File: rtl/multicycle_controller_pkg.sv
// Shared constants for the multicycle RV32I control path:
// opcodes, FSM states, ALUOp/ALUControl and ImmSrc codes.
package multicycle_controller_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BEQ    = 4'd9,
    S_TRAP   = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  function automatic logic [1:0] imm_src(input logic [6:0] op);
    case (op)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      default: imm_src = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps ALUOp and funct fields to ALUControl.
// Only R-type (op[5]=1) with instr[30]=1 selects subtract.
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  aluop_t      alu_op,
  input  logic [2:0]  funct3,
  input  logic        op5,
  input  logic        funct7b5,
  output logic [2:0]  alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: Moore decode from state, with
// PCWrite gated by zero, ALUControl by funct and ImmSrc by op.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter bit TRAP_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       instr_done,
  output logic       illegal_instr
);

  state_t state;
  state_t next;
  aluop_t alu_op;
  logic   pc_update;
  logic   branch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= next;
  end

  always_comb begin
    next          = S_FETCH;
    pc_update     = 1'b0;
    branch        = 1'b0;
    AdrSrc        = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    RegWrite      = 1'b0;
    ResultSrc     = RES_ALUOUT;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_RS2;
    alu_op        = ALUOP_ADD;
    instr_done    = 1'b0;
    illegal_instr = 1'b0;
    case (state)
      S_FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        pc_update = 1'b1;
        next      = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: next = S_MEMADR;
          OP_R:         next = S_EXECR;
          OP_I:         next = S_EXECI;
          OP_BEQ:       next = S_BEQ;
          default:      next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        next    = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc = 1'b1;
        next   = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        alu_op  = ALUOP_FUNCT;
        next    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
        next    = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        alu_op     = ALUOP_SUB;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      S_TRAP: begin
        illegal_instr = 1'b1;
        if (TRAP_HALT) begin
          next = S_TRAP;
        end else begin
          next       = S_FETCH;
          instr_done = 1'b1;
        end
      end
      default: next = S_FETCH;
    endcase
  end

  assign PCWrite = pc_update | (branch & zero);
  assign ImmSrc  = imm_src(op);

  alu_decoder u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed scoreboard bench for multicycle_controller, with a
// halting (TRAP_HALT=1) and a non-halting (TRAP_HALT=0) instance.
module tb_multicycle_controller;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;

  logic       pcw1, adr1, mw1, irw1, rw1, done1, ill1;
  logic [1:0] rs1, sa1, sb1, imm1;
  logic [2:0] alu1;
  logic       pcw0, adr0, mw0, irw0, rw0, done0, ill0;
  logic [1:0] rs0, sa0, sb0, imm0;
  logic [2:0] alu0;

  logic [17:0] obs1, obs0;
  assign obs1 = {pcw1, adr1, mw1, irw1, rw1, rs1, sa1, sb1,
                 alu1, imm1, done1, ill1};
  assign obs0 = {pcw0, adr0, mw0, irw0, rw0, rs0, sa0, sb0,
                 alu0, imm0, done0, ill0};

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    logic [17:0] e1;
    logic [17:0] e0;
    bit          chk0;
  } exp_t;
  exp_t sb[$];

  multicycle_controller #(.TRAP_HALT(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero),
    .PCWrite(pcw1), .AdrSrc(adr1), .MemWrite(mw1),
    .IRWrite(irw1), .RegWrite(rw1), .ResultSrc(rs1),
    .ALUSrcA(sa1), .ALUSrcB(sb1), .ALUControl(alu1),
    .ImmSrc(imm1), .instr_done(done1), .illegal_instr(ill1)
  );

  multicycle_controller #(.TRAP_HALT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero),
    .PCWrite(pcw0), .AdrSrc(adr0), .MemWrite(mw0),
    .IRWrite(irw0), .RegWrite(rw0), .ResultSrc(rs0),
    .ALUSrcA(sa0), .ALUSrcB(sb0), .ALUControl(alu0),
    .ImmSrc(imm0), .instr_done(done0), .illegal_instr(ill0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  function automatic logic [17:0] mk(
    input logic pcw, input logic adr, input logic mw,
    input logic irw, input logic rw, input logic [1:0] rs,
    input logic [1:0] sa, input logic [1:0] sbv,
    input logic [2:0] alu, input logic [1:0] im,
    input logic dn, input logic il);
    mk = {pcw, adr, mw, irw, rw, rs, sa, sbv, alu, im, dn, il};
  endfunction

  function automatic logic [1:0] imm_model(input logic [6:0] o);
    if (o == SW)      imm_model = 2'b01;
    else if (o == BQ) imm_model = 2'b10;
    else              imm_model = 2'b00;
  endfunction

  function automatic logic [2:0] alu_model(
    input logic o5, input logic [2:0] f, input logic b);
    case (f)
      3'b000:  alu_model = (o5 && b) ? 3'b001 : 3'b000;
      3'b010:  alu_model = 3'b101;
      3'b110:  alu_model = 3'b011;
      3'b111:  alu_model = 3'b010;
      default: alu_model = 3'b000;
    endcase
  endfunction

  function automatic logic [17:0] st_f(input logic [1:0] im);
    st_f = mk(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,im,0,0);
  endfunction
  function automatic logic [17:0] st_d(input logic [1:0] im);
    st_d = mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,im,0,0);
  endfunction
  function automatic logic [17:0] st_ma(input logic [1:0] im);
    st_ma = mk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,im,0,0);
  endfunction
  function automatic logic [17:0] st_mr(input logic [1:0] im);
    st_mr = mk(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,im,0,0);
  endfunction
  function automatic logic [17:0] st_mwb(input logic [1:0] im);
    st_mwb = mk(0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,im,1,0);
  endfunction
  function automatic logic [17:0] st_mwr(input logic [1:0] im);
    st_mwr = mk(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,im,1,0);
  endfunction
  function automatic logic [17:0] st_er(
    input logic [1:0] im, input logic [2:0] a);
    st_er = mk(0,0,0,0,0,2'b00,2'b10,2'b00,a,im,0,0);
  endfunction
  function automatic logic [17:0] st_ei(
    input logic [1:0] im, input logic [2:0] a);
    st_ei = mk(0,0,0,0,0,2'b00,2'b10,2'b01,a,im,0,0);
  endfunction
  function automatic logic [17:0] st_awb(input logic [1:0] im);
    st_awb = mk(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,im,1,0);
  endfunction
  function automatic logic [17:0] st_beq(
    input logic [1:0] im, input logic z);
    st_beq = mk(z,0,0,0,0,2'b00,2'b10,2'b00,3'b001,im,1,0);
  endfunction
  function automatic logic [17:0] st_trap(
    input logic [1:0] im, input logic dn);
    st_trap = mk(0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,im,dn,1);
  endfunction

  task automatic chk(input string tag, input logic [17:0] e1,
                     input logic [17:0] e0, input bit c0);
    exp_t it;
    sb.push_back('{tag, e1, e0, c0});
    it = sb.pop_front();
    vectors++;
    assert (obs1 === it.e1) else begin
      miscompares++;
      $error("FAIL %s: observed %05h expected %05h",
             it.tag, obs1, it.e1);
    end
    if (it.chk0) begin
      vectors++;
      assert (obs0 === it.e0) else begin
        miscompares++;
        $error("FAIL %s/halt0: observed %05h expected %05h",
               it.tag, obs0, it.e0);
      end
    end
  endtask

  task automatic cyc2(input string tag, input logic [17:0] e1,
                      input logic [17:0] e0);
    @(negedge clk);
    chk(tag, e1, e0, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string tag, input logic [17:0] e);
    cyc2(tag, e, e);
  endtask

  task automatic run(input string tag, input logic [6:0] o,
                     input logic [2:0] f, input logic b,
                     input logic z);
    logic [1:0] im;
    logic [2:0] a;
    im = imm_model(o);
    a  = alu_model(o[5], f, b);
    op = o; funct3 = f; funct7b5 = b; zero = ~z;
    cyc({tag, ".fetch"},  st_f(im));
    cyc({tag, ".decode"}, st_d(im));
    if (o == LW) begin
      cyc({tag, ".memadr"}, st_ma(im));
      cyc({tag, ".memrd"},  st_mr(im));
      cyc({tag, ".memwb"},  st_mwb(im));
    end else if (o == SW) begin
      cyc({tag, ".memadr"}, st_ma(im));
      cyc({tag, ".memwr"},  st_mwr(im));
    end else if (o == RT) begin
      cyc({tag, ".execr"}, st_er(im, a));
      cyc({tag, ".aluwb"}, st_awb(im));
    end else if (o == IT) begin
      cyc({tag, ".execi"}, st_ei(im, a));
      cyc({tag, ".aluwb"}, st_awb(im));
    end else begin
      zero = z;
      cyc({tag, ".beq"}, st_beq(im, z));
      zero = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; op = LW; funct3 = 3'b010;
    funct7b5 = 1'b0; zero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset", st_f(2'b00), st_f(2'b00), 1'b1);
    @(posedge clk);
    #1 reset = 1'b0;

    run("lw",      LW, 3'b010, 1'b0, 1'b0);
    run("sw",      SW, 3'b010, 1'b0, 1'b0);
    run("sub",     RT, 3'b000, 1'b1, 1'b0);
    run("add",     RT, 3'b000, 1'b0, 1'b0);
    run("addi30",  IT, 3'b000, 1'b1, 1'b0);
    run("slt",     RT, 3'b010, 1'b0, 1'b0);
    run("slti",    IT, 3'b010, 1'b0, 1'b0);
    run("or",      RT, 3'b110, 1'b0, 1'b0);
    run("andi",    IT, 3'b111, 1'b1, 1'b0);
    run("xor_def", RT, 3'b100, 1'b0, 1'b0);
    run("beq_tk",  BQ, 3'b000, 1'b0, 1'b1);
    run("beq_nt",  BQ, 3'b000, 1'b0, 1'b0);

    op = LW; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
    cyc("rmid.fetch",  st_f(2'b00));
    cyc("rmid.decode", st_d(2'b00));
    cyc("rmid.memadr", st_ma(2'b00));
    #1 chk("rmid.memrd", st_mr(2'b00), st_mr(2'b00), 1'b1);
    reset = 1'b1;
    #1 chk("rmid.async", st_f(2'b00), st_f(2'b00), 1'b1);
    cyc("rmid.hold", st_f(2'b00));
    reset = 1'b0;
    run("lw_after", LW, 3'b010, 1'b0, 1'b0);

    op = BAD; funct3 = 3'b000; funct7b5 = 1'b0;
    cyc("trap.fetch",  st_f(2'b00));
    cyc("trap.decode", st_d(2'b00));
    cyc2("trap.1", st_trap(2'b00, 1'b0), st_trap(2'b00, 1'b1));
    cyc2("trap.2", st_trap(2'b00, 1'b0), st_f(2'b00));
    cyc2("trap.3", st_trap(2'b00, 1'b0), st_d(2'b00));
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    run("sw_after", SW, 3'b000, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
